pll_speed_sequencer: RTL and testbench
======================================

PLL_SPEED_SEQUENCER -- requirements
Module: pll_speed_sequencer

Interface
REQ-001 Parameter K_NATIVE, default 32'd3639383488, fractional-K word for native speed.
REQ-002 Parameter K_UNDER, default 32'd2977614927, fractional-K word for the 60Hz-adjust underclock.
REQ-003 Parameter K_BOOT, default 32'd2748778984, fractional-K word for bootleg boards.
REQ-004 Parameter GAP, default 3, number of idle cycles between consecutive register writes.
REQ-005 Parameter LOCK_TMO, default 16'hFFFF, lock-wait timeout in cycles.
REQ-006 clk_50m  in  1  reconfig management clock; all logic runs on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 underclock  in  1  asynchronous speed request (OSD, clk_49m domain).
REQ-009 bootleg  in  1  asynchronous board-type request (clk_49m domain).
REQ-010 pll_locked  in  1  asynchronous PLL lock indicator.
REQ-011 mgmt_waitrequest  in  1  reconfig IP stall.
REQ-012 mgmt_write  out  1  write strobe.
REQ-013 mgmt_address  out  6  register address.
REQ-014 mgmt_writedata  out  32  register data.
REQ-015 busy  out  1  high while a sequence is in flight.
REQ-016 done  out  1  one-cycle pulse when the PLL relocks after a sequence.
REQ-017 lock_err  out  1  sticky flag, set on lock timeout.

Function
REQ-018 underclock, bootleg and pll_locked each SHALL pass through a 2-flop synchronizer; a request bit is "stable" only when two consecutive synchronized samples are equal.
REQ-019 The target word SHALL be K_BOOT if bootleg is stable-high, else K_UNDER if underclock is stable-high, else K_NATIVE; an unstable bit SHALL keep its previous stable value.
REQ-020 Register applied_k SHALL hold the last word sequenced; a sequence SHALL start only when the target differs from applied_k.
REQ-021 States: IDLE, WR_MODE, GAP1, WR_FRAC, GAP2, WR_START, LOCK_LO, LOCK_HI.
REQ-022 IDLE->WR_MODE on a target/applied_k mismatch; applied_k SHALL latch the target in the same cycle.
REQ-023 WR_MODE: address 0, data 0; WR_FRAC: address 7, data applied_k; WR_START: address 2, data 0.
REQ-024 In WR_* states mgmt_write SHALL be 1 with address and data held constant.
REQ-025 A write SHALL complete on the first cycle with mgmt_write=1 and mgmt_waitrequest=0; the next state follows and mgmt_write deasserts in that next cycle.
REQ-026 GAP1/GAP2 SHALL hold mgmt_write=0 for GAP cycles, counting only cycles with mgmt_waitrequest=0.
REQ-027 LOCK_LO SHALL wait for synchronized pll_locked=0; LOCK_HI SHALL wait for pll_locked=1, then pulse done and go to IDLE.
REQ-028 Any cycle in LOCK_LO or LOCK_HI SHALL increment a shared timeout counter; on reaching LOCK_TMO the block SHALL set lock_err, go to IDLE and not pulse done.
REQ-029 The timeout counter SHALL clear on entry to LOCK_LO.
REQ-030 A target change during WR_*/GAP* SHALL NOT alter the current sequence; it is serviced by the REQ-022 mismatch check on return to IDLE.
REQ-031 A target change during LOCK_* SHALL NOT be lost and is likewise serviced from IDLE.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 mgmt_address and mgmt_writedata SHALL be 0 outside WR_* states.
REQ-034 A back-to-back IDLE->WR_MODE transition after done SHALL be permitted (zero idle cycles).

Reset
REQ-035 Reset SHALL force IDLE, applied_k=K_NATIVE, all counters and synchronizers to 0, and mgmt_write=0, mgmt_address=0, mgmt_writedata=0, busy=0, done=0, lock_err=0.
REQ-036 Reset asserted mid-write SHALL drop mgmt_write immediately (asynchronously).
REQ-037 Release from reset SHALL begin in IDLE, with no sequence unless the target differs from K_NATIVE.

Verification
REQ-038 Scenario: reset released with underclock=1, waitrequest=0, lock toggling -> writes (0,0), (7,2977614927), (2,0) with GAP=3 idle cycles between; done pulses once.
REQ-039 Scenario: bootleg=1 and underclock=1 -> data 2748778984 at address 7; then clear bootleg -> new sequence with 2977614927.
REQ-040 Scenario: waitrequest held high 10 cycles during WR_FRAC -> mgmt_write, address 7 and data stable for all 11 cycles; exactly one write accepted.
REQ-041 Scenario: underclock toggles 1->0 during GAP1 -> first sequence completes with K_UNDER; a second sequence with 3639383488 starts from IDLE.
REQ-042 Scenario: pll_locked stuck high after WR_START, LOCK_TMO=16 -> lock_err=1 after 16 cycles; no done pulse; busy=0.
REQ-043 Scenario: reset asserted in WR_MODE -> mgmt_write=0 at once; no writes after release with all requests 0.

Source files
------------

// File: rtl/pll_speed_sequencer.sv
// Reprograms the fractional-K word of the video PLL through the reconfig management port
// whenever the requested speed (native / underclock / bootleg) changes, then waits for relock.
module pll_speed_sequencer #(
  parameter logic [31:0] K_NATIVE = 32'd3639383488,
  parameter logic [31:0] K_UNDER  = 32'd2977614927,
  parameter logic [31:0] K_BOOT   = 32'd2748778984,
  parameter int unsigned GAP      = 3,
  parameter logic [15:0] LOCK_TMO = 16'hFFFF
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic        underclock,
  input  logic        bootleg,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
  output logic        done,
  output logic        lock_err
);

  // state    | meaning
  // IDLE     | compare target word against applied_k
  // WR_MODE  | write mode register (addr 0)
  // GAP1     | idle spacing after mode write
  // WR_FRAC  | write fractional-K word (addr 7)
  // GAP2     | idle spacing after K write
  // WR_START | kick reconfiguration (addr 2)
  // LOCK_LO  | wait for the PLL to drop lock
  // LOCK_HI  | wait for the PLL to regain lock
  typedef enum logic [2:0] {
    IDLE, WR_MODE, GAP1, WR_FRAC, GAP2, WR_START, LOCK_LO, LOCK_HI
  } state_t;

  localparam logic [15:0] GAP_LD = 16'(GAP);

  state_t      state;
  logic [31:0] applied_k;
  logic [31:0] target_k;
  logic [15:0] gap_cnt;
  logic [15:0] tmo_cnt;

  logic uc_s1, uc_s2, uc_s3, uc_stable;
  logic bl_s1, bl_s2, bl_s3, bl_stable;
  logic pl_s1, pl_s2;

  always_comb begin
    target_k = K_NATIVE;
    if (bl_stable)      target_k = K_BOOT;
    else if (uc_stable) target_k = K_UNDER;
  end

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      applied_k      <= K_NATIVE;
      gap_cnt        <= '0;
      tmo_cnt        <= '0;
      uc_s1          <= 1'b0;
      uc_s2          <= 1'b0;
      uc_s3          <= 1'b0;
      uc_stable      <= 1'b0;
      bl_s1          <= 1'b0;
      bl_s2          <= 1'b0;
      bl_s3          <= 1'b0;
      bl_stable      <= 1'b0;
      pl_s1          <= 1'b0;
      pl_s2          <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      lock_err       <= 1'b0;
    end else begin
      uc_s1 <= underclock;
      uc_s2 <= uc_s1;
      uc_s3 <= uc_s2;
      bl_s1 <= bootleg;
      bl_s2 <= bl_s1;
      bl_s3 <= bl_s2;
      pl_s1 <= pll_locked;
      pl_s2 <= pl_s1;
      // a request bit only moves once two consecutive synchronized samples agree
      if (uc_s2 == uc_s3) uc_stable <= uc_s2;
      if (bl_s2 == bl_s3) bl_stable <= bl_s2;

      done <= 1'b0;

      case (state)
        IDLE: begin
          if (target_k != applied_k) begin
            applied_k      <= target_k;
            state          <= WR_MODE;
            mgmt_write     <= 1'b1;
            mgmt_address   <= 6'd0;
            mgmt_writedata <= 32'd0;
            busy           <= 1'b1;
          end
        end
        WR_MODE: begin
          if (!mgmt_waitrequest) begin
            state      <= GAP1;
            mgmt_write <= 1'b0;
            gap_cnt    <= GAP_LD;
          end
        end
        GAP1: begin
          if (!mgmt_waitrequest) begin
            if (gap_cnt <= 16'd1) begin
              state          <= WR_FRAC;
              mgmt_write     <= 1'b1;
              mgmt_address   <= 6'd7;
              mgmt_writedata <= applied_k;
            end else begin
              gap_cnt <= gap_cnt - 16'd1;
            end
          end
        end
        WR_FRAC: begin
          if (!mgmt_waitrequest) begin
            state          <= GAP2;
            mgmt_write     <= 1'b0;
            mgmt_address   <= 6'd0;
            mgmt_writedata <= 32'd0;
            gap_cnt        <= GAP_LD;
          end
        end
        GAP2: begin
          if (!mgmt_waitrequest) begin
            if (gap_cnt <= 16'd1) begin
              state          <= WR_START;
              mgmt_write     <= 1'b1;
              mgmt_address   <= 6'd2;
              mgmt_writedata <= 32'd0;
            end else begin
              gap_cnt <= gap_cnt - 16'd1;
            end
          end
        end
        WR_START: begin
          if (!mgmt_waitrequest) begin
            state        <= LOCK_LO;
            mgmt_write   <= 1'b0;
            mgmt_address <= 6'd0;
            tmo_cnt      <= LOCK_TMO;
          end
        end
        LOCK_LO: begin
          // one timeout budget spans both lock phases
          tmo_cnt <= tmo_cnt - 16'd1;
          if (!pl_s2) begin
            state <= LOCK_HI;
          end else if (tmo_cnt <= 16'd1) begin
            state    <= IDLE;
            busy     <= 1'b0;
            lock_err <= 1'b1;
          end
        end
        LOCK_HI: begin
          tmo_cnt <= tmo_cnt - 16'd1;
          if (pl_s2) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tmo_cnt <= 16'd1) begin
            state    <= IDLE;
            busy     <= 1'b0;
            lock_err <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          mgmt_write     <= 1'b0;
          mgmt_address   <= '0;
          mgmt_writedata <= '0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_speed_sequencer.sv
// Directed bench for pll_speed_sequencer: write sequences, stalls, request changes, lock timeout, reset.
module tb_pll_speed_sequencer;

  localparam logic [31:0] K_NATIVE = 32'd3639383488;
  localparam logic [31:0] K_UNDER  = 32'd2977614927;
  localparam logic [31:0] K_BOOT   = 32'd2748778984;

  logic        clk_50m = 1'b0;
  logic        reset = 1'b0;
  logic        underclock = 1'b0;
  logic        bootleg = 1'b0;
  logic        pll_locked = 1'b1;
  logic        mgmt_waitrequest = 1'b0;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        busy;
  logic        done;
  logic        lock_err;

  int checks = 0;
  int fails = 0;

  int          cyc = 0;
  int          wr_total = 0;
  int          done_total = 0;
  logic [5:0]  wr_addr [256];
  logic [31:0] wr_data [256];
  int          wr_cyc  [256];
  int          done_cyc[64];
  logic        pll_stuck = 1'b0;
  int          lo_cnt = 0;

  always #5 clk_50m = ~clk_50m;

  pll_speed_sequencer #(.LOCK_TMO(16'd16)) dut (
    .clk_50m          (clk_50m),
    .reset            (reset),
    .underclock       (underclock),
    .bootleg          (bootleg),
    .pll_locked       (pll_locked),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_write       (mgmt_write),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .busy             (busy),
    .done             (done),
    .lock_err         (lock_err)
  );

  // write log, done log and a PLL that drops lock for a few cycles after each start write
  always @(negedge clk_50m) begin
    cyc <= cyc + 1;
    if (reset && mgmt_write && !mgmt_waitrequest && wr_total < 256) begin
      wr_addr[wr_total] <= mgmt_address;
      wr_data[wr_total] <= mgmt_writedata;
      wr_cyc[wr_total]  <= cyc;
      wr_total          <= wr_total + 1;
    end
    if (done && done_total < 64) begin
      done_cyc[done_total] <= cyc;
      done_total           <= done_total + 1;
    end
    if (pll_stuck) begin
      pll_locked <= 1'b1;
      lo_cnt     <= 0;
    end else if (lo_cnt > 0) begin
      lo_cnt <= lo_cnt - 1;
      if (lo_cnt == 1) pll_locked <= 1'b1;
    end else if (reset && mgmt_write && !mgmt_waitrequest && mgmt_address == 6'd2) begin
      pll_locked <= 1'b0;
      lo_cnt     <= 4;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_50m);
    #2;
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_total < target && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (done_total < target) begin
      fails++;
      $display("FAIL %s_done_wait: done pulses %0d, required %0d", name, done_total, target);
    end
  endtask

  task automatic wait_mode_write(input string name);
    int n;
    n = 0;
    while (!(mgmt_write && mgmt_address == 6'd0) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!(mgmt_write && mgmt_address == 6'd0)) begin
      fails++;
      $display("FAIL %s_mode_wait: write=%0b addr=%0d, required write=1 addr=0", name, mgmt_write,
               mgmt_address);
    end
  endtask

  task automatic test_reset();
    int base;
    reset = 1'b0;
    underclock = 1'b0;
    bootleg = 1'b0;
    repeat (3) tick();
    checks++;
    if ({mgmt_write, busy, done, lock_err, mgmt_address, mgmt_writedata} !== 42'd0) begin
      fails++;
      $display("FAIL reset_outputs: write=%0b busy=%0b done=%0b err=%0b addr=%0d data=%0d, required all 0",
               mgmt_write, busy, done, lock_err, mgmt_address, mgmt_writedata);
    end
    reset = 1'b1;
    base = wr_total;
    repeat (20) tick();
    checks++;
    if (wr_total !== base || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: writes %0d busy %0b, required 0 writes busy 0",
               wr_total - base, busy);
    end
  endtask

  task automatic test_underclock_from_reset();
    int base, dbase;
    logic [5:0]  ea[3];
    logic [31:0] ed[3];
    reset = 1'b0;
    underclock = 1'b1;
    repeat (2) tick();
    base = wr_total;
    dbase = done_total;
    reset = 1'b1;
    wait_done(dbase + 1, "uc_reset");
    repeat (3) tick();
    ea[0] = 6'd0; ea[1] = 6'd7;  ea[2] = 6'd2;
    ed[0] = 32'd0; ed[1] = K_UNDER; ed[2] = 32'd0;
    checks++;
    if (wr_total - base !== 3) begin
      fails++;
      $display("FAIL uc_write_count: %0d writes, required 3", wr_total - base);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr[base+i] !== ea[i] || wr_data[base+i] !== ed[i]) begin
        fails++;
        $display("FAIL uc_write%0d: (%0d,%0d), required (%0d,%0d)", i, wr_addr[base+i],
                 wr_data[base+i], ea[i], ed[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wr_cyc[base+i+1] - wr_cyc[base+i] !== 4) begin
        fails++;
        $display("FAIL uc_gap%0d: spacing %0d cycles, required 4", i,
                 wr_cyc[base+i+1] - wr_cyc[base+i]);
      end
    end
    checks++;
    if (done_total !== dbase + 1 || busy !== 1'b0 || lock_err !== 1'b0) begin
      fails++;
      $display("FAIL uc_finish: done pulses %0d busy %0b err %0b, required 1 0 0",
               done_total - dbase, busy, lock_err);
    end
  endtask

  task automatic test_bootleg_priority();
    int base, dbase;
    base = wr_total;
    dbase = done_total;
    bootleg = 1'b1;
    wait_done(dbase + 1, "boot");
    checks++;
    if (wr_total - base !== 3 || wr_addr[base+1] !== 6'd7 || wr_data[base+1] !== K_BOOT) begin
      fails++;
      $display("FAIL boot_k: writes %0d addr %0d data %0d, required 3 7 %0d", wr_total - base,
               wr_addr[base+1], wr_data[base+1], K_BOOT);
    end
    repeat (2) tick();
    base = wr_total;
    dbase = done_total;
    bootleg = 1'b0;
    wait_done(dbase + 1, "boot_clear");
    checks++;
    if (wr_total - base !== 3 || wr_addr[base+1] !== 6'd7 || wr_data[base+1] !== K_UNDER) begin
      fails++;
      $display("FAIL boot_clear_k: writes %0d addr %0d data %0d, required 3 7 %0d", wr_total - base,
               wr_addr[base+1], wr_data[base+1], K_UNDER);
    end
  endtask

  task automatic test_waitreq_stall();
    int base, dbase, n7;
    logic stable;
    repeat (2) tick();
    base = wr_total;
    dbase = done_total;
    underclock = 1'b0;
    wait_mode_write("stall");
    repeat (4) tick();
    checks++;
    if (mgmt_write !== 1'b1 || mgmt_address !== 6'd7 || mgmt_writedata !== K_NATIVE) begin
      fails++;
      $display("FAIL stall_enter_frac: write=%0b addr=%0d data=%0d, required 1 7 %0d", mgmt_write,
               mgmt_address, mgmt_writedata, K_NATIVE);
    end
    mgmt_waitrequest = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mgmt_write !== 1'b1 || mgmt_address !== 6'd7 || mgmt_writedata !== K_NATIVE) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      fails++;
      $display("FAIL stall_hold: outputs changed during waitrequest, required held write=1 addr=7");
    end
    mgmt_waitrequest = 1'b0;
    wait_done(dbase + 1, "stall");
    n7 = 0;
    for (int i = base; i < wr_total; i++) if (wr_addr[i] == 6'd7) n7++;
    checks++;
    if (n7 !== 1 || wr_total - base !== 3) begin
      fails++;
      $display("FAIL stall_accept_count: %0d addr7 writes of %0d, required 1 of 3", n7,
               wr_total - base);
    end
  endtask

  task automatic test_change_in_gap();
    int base, dbase;
    repeat (2) tick();
    base = wr_total;
    dbase = done_total;
    underclock = 1'b1;
    wait_mode_write("gapchg");
    tick();
    checks++;
    if (mgmt_write !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL gapchg_in_gap1: write=%0b busy=%0b, required 0 1", mgmt_write, busy);
    end
    underclock = 1'b0;
    wait_done(dbase + 2, "gapchg");
    checks++;
    if (wr_total - base !== 6 || wr_data[base+1] !== K_UNDER || wr_data[base+4] !== K_NATIVE) begin
      fails++;
      $display("FAIL gapchg_words: writes %0d k1 %0d k2 %0d, required 6 %0d %0d", wr_total - base,
               wr_data[base+1], wr_data[base+4], K_UNDER, K_NATIVE);
    end
    checks++;
    if (wr_cyc[base+3] - done_cyc[dbase] !== 1) begin
      fails++;
      $display("FAIL back_to_back: done-to-mode-write %0d cycles, required 1",
               wr_cyc[base+3] - done_cyc[dbase]);
    end
  endtask

  task automatic test_lock_timeout();
    int base, dbase, n;
    repeat (2) tick();
    pll_stuck = 1'b1;
    base = wr_total;
    dbase = done_total;
    underclock = 1'b1;
    n = 0;
    while (wr_total < base + 3 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (wr_total < base + 3) begin
      fails++;
      $display("FAIL tmo_start_write: %0d writes, required 3", wr_total - base);
    end
    repeat (15) tick();
    checks++;
    if (lock_err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL tmo_before: err=%0b busy=%0b after 15 cycles, required 0 1", lock_err, busy);
    end
    tick();
    checks++;
    if (lock_err !== 1'b1 || busy !== 1'b0 || done_total !== dbase) begin
      fails++;
      $display("FAIL tmo_expire: err=%0b busy=%0b done pulses %0d after 16 cycles, required 1 0 0",
               lock_err, busy, done_total - dbase);
    end
    pll_stuck = 1'b0;
    repeat (10) tick();
    checks++;
    if (lock_err !== 1'b1 || busy !== 1'b0 || wr_total !== base + 3) begin
      fails++;
      $display("FAIL tmo_sticky: err=%0b busy=%0b extra writes %0d, required 1 0 0", lock_err, busy,
               wr_total - base - 3);
    end
  endtask

  task automatic test_reset_midwrite();
    int base;
    underclock = 1'b0;
    wait_mode_write("rstmid");
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (mgmt_write !== 1'b0 || busy !== 1'b0 || lock_err !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async: write=%0b busy=%0b err=%0b, required 0 0 0", mgmt_write, busy,
               lock_err);
    end
    base = wr_total;
    repeat (3) tick();
    reset = 1'b1;
    repeat (30) tick();
    checks++;
    if (wr_total !== base || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_release: %0d writes busy %0b, required 0 writes busy 0", wr_total - base,
               busy);
    end
  endtask

  initial begin
    test_reset();
    test_underclock_from_reset();
    test_bootleg_priority();
    test_waitreq_stall();
    test_change_in_gap();
    test_lock_timeout();
    test_reset_midwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
